// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and instruction fetch sequencer with decode handshake
module fetch_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INST_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [PC_W-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   fetch_pc
);

  // IDLE: post-reset bubble; REQ: offering a fetch; WAIT: response pending;
  // FLUSH: response pending but stale after a redirect.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_t;

  state_t              state, state_n;
  logic [PC_W-1:0]     inflight_pc, inflight_pc_n;
  logic [PC_W-1:0]     fetch_pc_n;
  logic [PC_W-1:0]     inst_pc_n;
  logic [INST_W-1:0]   inst_data_n;
  logic                inst_valid_n;
  logic                granted;

  // Request only when the output register will be free when the 1-cycle response lands.
  assign imem_req  = (state == S_REQ) && (!inst_valid || inst_ready);
  assign imem_addr = fetch_pc;
  assign granted   = imem_req && imem_gnt;

  // Next-state and next-register values; a redirect overrides the normal transitions.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    inflight_pc_n = inflight_pc;
    inst_valid_n  = inst_valid;
    inst_pc_n     = inst_pc;
    inst_data_n   = inst_data;

    if (inst_valid && inst_ready) begin
      inst_valid_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        if (granted) begin
          inflight_pc_n = fetch_pc;
          fetch_pc_n    = fetch_pc + PC_W'(1);
          state_n       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_valid_n = 1'b1;
          inst_pc_n    = inflight_pc;
          inst_data_n  = imem_rdata;
          state_n      = S_REQ;
        end
      end
      S_FLUSH: begin
        if (imem_rvalid) begin
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_n    = redirect_pc;
      inflight_pc_n = inflight_pc;
      inst_valid_n  = 1'b0;
      inst_pc_n     = inst_pc;
      inst_data_n   = inst_data;
      case (state)
        S_IDLE:  state_n = S_REQ;
        S_REQ:   state_n = granted ? S_FLUSH : S_REQ;
        S_WAIT:  state_n = imem_rvalid ? S_REQ : S_FLUSH;
        S_FLUSH: state_n = imem_rvalid ? S_REQ : S_FLUSH;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inst_valid  <= 1'b0;
      inst_pc     <= '0;
      inst_data   <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      inflight_pc <= inflight_pc_n;
      inst_valid  <= inst_valid_n;
      inst_pc     <= inst_pc_n;
      inst_data   <= inst_data_n;
    end
  end

endmodule
